nbody_readback: RTL and testbench



---
 rtl/nbody_readback.sv | 143 ++++++++++++++
 tb/tb_nbody_readback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nbody_readback.sv
// nbody_readback: polls nbody DONE, reads every body's X/Y doubles, emits pixel points, then releases nbody.
// Define NBODY_READBACK_CLAMP_EN to clamp off-screen bodies to the screen edge instead of dropping them.
module nbody_readback #(
   parameter int BODIES          = 512,
   parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 16,
   parameter int READ_LAT        = 2,
   parameter int POLL_GAP        = 16,
   parameter int SCALE_SHIFT     = 0,
   parameter int X_RES           = 640,
   parameter int Y_RES           = 480,
   parameter int PIX_W           = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
   output logic                       nb_chipselect,
   output logic                       nb_read,
   output logic                       nb_write,
   output logic [ADDR_WIDTH-1:0]      nb_addr,
   output logic [DATA_WIDTH-1:0]      nb_writedata,
   input  logic [DATA_WIDTH-1:0]      nb_readdata,
   output logic                       pt_valid,
   input  logic                       pt_ready,
   output logic [PIX_W-1:0]           pt_x,
   output logic [PIX_W-1:0]           pt_y,
   output logic [BODY_ADDR_WIDTH-1:0] pt_idx,
   output logic                       pt_last,
   output logic                       frame_done,
   output logic                       busy,
   output logic [BODY_ADDR_WIDTH:0]   off_count
);
   localparam int OPW = ADDR_WIDTH - BODY_ADDR_WIDTH;
   localparam int CW  = $clog2(POLL_GAP + READ_LAT + 1);
   localparam logic [CW-1:0] LAT_END = CW'(READ_LAT - 1);
   localparam logic [CW-1:0] GAP_END = CW'(POLL_GAP - 1);
   localparam logic signed [19:0] BIG   = 20'sd131072;
   localparam logic signed [19:0] X_MID = 20'(X_RES / 2);
   localparam logic signed [19:0] Y_MID = 20'(Y_RES / 2);
   localparam logic signed [19:0] X_MAX = 20'(X_RES - 1);
   localparam logic signed [19:0] Y_MAX = 20'(Y_RES - 1);
   localparam logic [BODY_ADDR_WIDTH-1:0] ZERO_IDX = '0;
`ifdef NBODY_READBACK_CLAMP_EN
   localparam bit CLAMP = 1'b1;
`else
   localparam bit CLAMP = 1'b0;
`endif
   localparam logic [3:0] IDLE = 4'd0, POLL = 4'd1, POLL_W = 4'd2, GAP = 4'd3,
                          RD_X = 4'd4, WAIT_X = 4'd5, RD_Y = 4'd6, WAIT_Y = 4'd7,
                          CONV = 4'd8, EMIT = 4'd9, REL_SET = 4'd10, REL_CLR = 4'd11;
   logic [3:0] state;
   logic [CW-1:0] cnt;
   logic [BODY_ADDR_WIDTH-1:0] i, n;
   logic [63:0] rx, ry;
   logic signed [19:0] cx, cy, sx, sy, qx, qy;
   logic off, last, drop;
   // Anything beyond 2^16 world units is off every screen, so it saturates to a sign-carrying sentinel.
   function automatic logic signed [19:0] conv(input logic [63:0] d);
      int k;
      logic [52:0] m;
      k = int'({21'd0, d[62:52]}) - 1023 - SCALE_SHIFT;
      m = {1'b1, d[51:0]} >> (52 - k);
      conv = (d[62:52] == 11'd0 || k < 0) ? 20'sd0
           : (k > 15) ? (d[63] ? -BIG : BIG)
           : (d[63] ? -$signed({4'd0, m[15:0]}) : $signed({4'd0, m[15:0]}));
   endfunction
   always_comb begin
      cx   = conv(rx);
      cy   = conv(ry);
      sx   = X_MID + cx;
      sy   = Y_MID - cy;
      off  = sx < 20'sd0 || sx > X_MAX || sy < 20'sd0 || sy > Y_MAX;
      qx   = sx < 20'sd0 ? 20'sd0 : sx > X_MAX ? X_MAX : sx;
      qy   = sy < 20'sd0 ? 20'sd0 : sy > Y_MAX ? Y_MAX : sy;
      last = i == n - BODY_ADDR_WIDTH'(1);
      drop = off & ~CLAMP;
   end
   assign busy          = state != IDLE;
   assign pt_valid      = state == EMIT;
   assign pt_idx        = i;
   assign nb_read       = state == POLL || state == RD_X || state == RD_Y;
   assign nb_write      = state == REL_SET || state == REL_CLR;
   assign nb_chipselect = nb_read | nb_write;
   assign nb_writedata  = DATA_WIDTH'(state == REL_SET);
   // Address stays on the bus from the read pulse through the capture cycle.
   assign nb_addr = (state == POLL || state == POLL_W) ? {OPW'(7'h40), ZERO_IDX}
                  : (state == RD_X || state == WAIT_X) ? {OPW'(7'h41), i}
                  : (state == RD_Y || state == WAIT_Y) ? {OPW'(7'h42), i}
                  : nb_write ? {OPW'(7'h01), ZERO_IDX} : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         i          <= '0;
         n          <= '0;
         rx         <= '0;
         ry         <= '0;
         pt_x       <= '0;
         pt_y       <= '0;
         pt_last    <= 1'b0;
         off_count  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= state == REL_CLR;
         case (state)
            IDLE:    if (start) state <= POLL;
            POLL:    begin cnt <= '0; state <= POLL_W; end
            POLL_W:  if (cnt == LAT_END) begin
                        cnt <= '0;
                        if (nb_readdata[0]) begin
                           n         <= num_bodies;
                           i         <= '0;
                           off_count <= '0;
                           state     <= num_bodies == ZERO_IDX ? REL_SET : RD_X;
                        end else state <= GAP;
                     end else cnt <= cnt + CW'(1);
            GAP:     if (cnt == GAP_END) state <= POLL; else cnt <= cnt + CW'(1);
            RD_X:    begin cnt <= '0; state <= WAIT_X; end
            WAIT_X:  if (cnt == LAT_END) begin rx <= nb_readdata; state <= RD_Y; end
                     else cnt <= cnt + CW'(1);
            RD_Y:    begin cnt <= '0; state <= WAIT_Y; end
            WAIT_Y:  if (cnt == LAT_END) begin ry <= nb_readdata; state <= CONV; end
                     else cnt <= cnt + CW'(1);
            CONV:    begin
                        pt_x      <= qx[PIX_W-1:0];
                        pt_y      <= qy[PIX_W-1:0];
                        pt_last   <= last;
                        off_count <= off_count + {{BODY_ADDR_WIDTH{1'b0}}, off};
                        state     <= !drop ? EMIT : last ? REL_SET : RD_X;
                        if (drop && !last) i <= i + BODY_ADDR_WIDTH'(1);
                     end
            EMIT:    if (pt_ready) begin
                        state <= pt_last ? REL_SET : RD_X;
                        if (!pt_last) i <= i + BODY_ADDR_WIDTH'(1);
                     end
            REL_SET: state <= REL_CLR;
            REL_CLR: state <= start ? POLL : IDLE;
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_nbody_readback.sv
// tb_nbody_readback: directed frames against a latency-accurate nbody slave model with a point scoreboard.
module tb_nbody_readback;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, pt_ready = 1'b1;
   logic [8:0] num_bodies = '0;
   logic nb_chipselect, nb_read, nb_write, pt_valid, pt_last, frame_done, busy;
   logic [15:0] nb_addr;
   logic [63:0] nb_writedata, nb_readdata = '0, p1 = '0;
   logic [9:0] pt_x, pt_y, off_count;
   logic [8:0] pt_idx;
   int compared = 0, mismatched = 0, cyc = 0, strobes = 0;
   logic [63:0] xmem [512];
   logic [63:0] ymem [512];
   bit done_q[$];
   logic [15:0] rd_log[$];
   logic [79:0] wr_log[$];
   int poll_cyc[$];
   logic [29:0] exp_q[$];
   logic [29:0] got, want;

   always #5 clk = ~clk;

   nbody_readback dut (
      .clk(clk), .rst_n(rst_n), .start(start), .num_bodies(num_bodies),
      .nb_chipselect(nb_chipselect), .nb_read(nb_read), .nb_write(nb_write),
      .nb_addr(nb_addr), .nb_writedata(nb_writedata), .nb_readdata(nb_readdata),
      .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_x(pt_x), .pt_y(pt_y),
      .pt_idx(pt_idx), .pt_last(pt_last), .frame_done(frame_done), .busy(busy),
      .off_count(off_count)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [29:0] pt(input int x, input int y, input int idx, input bit l);
      return {10'(x), 10'(y), 9'(idx), l};
   endfunction

   // nbody slave: read data appears exactly two cycles after the pulse and only for one cycle.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      p1  <= '0;
      if (nb_chipselect) strobes <= strobes + 1;
      if (nb_chipselect && nb_read) begin
         rd_log.push_back(nb_addr);
         if (nb_addr[15:9] == 7'h40) begin
            poll_cyc.push_back(cyc);
            if (done_q.size() > 0) p1 <= {63'd0, done_q.pop_front()};
            else p1 <= 64'd1;
         end else if (nb_addr[15:9] == 7'h41) p1 <= xmem[nb_addr[8:0]];
         else if (nb_addr[15:9] == 7'h42) p1 <= ymem[nb_addr[8:0]];
      end
      if (nb_chipselect && nb_write) wr_log.push_back({nb_addr, nb_writedata});
      nb_readdata <= p1;
   end

   always @(negedge clk)
      if (pt_valid && pt_ready) begin
         got = {pt_x, pt_y, pt_idx, pt_last};
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $error("FAIL extra_point: observed %0h expected none", got);
         end else begin
            want = exp_q.pop_front();
            check("point", got, want);
         end
      end

   task automatic body(input int idx, input logic [63:0] x, input logic [63:0] y);
      xmem[idx] = x;
      ymem[idx] = y;
   endtask

   task automatic clear_logs();
      rd_log.delete();
      wr_log.delete();
      poll_cyc.delete();
   endtask

   task automatic wait_frame(input string tag);
      int k = 0;
      while (frame_done !== 1'b1 && k < 3000) begin @(negedge clk); k++; end
      check({tag, "_frame_done"}, frame_done, 1);
   endtask

   task automatic wait_valid(input string tag);
      int k = 0;
      while (pt_valid !== 1'b1 && k < 500) begin @(negedge clk); k++; end
      check({tag, "_valid"}, pt_valid, 1);
   endtask

   task automatic run_frame(input int n, input string tag);
      num_bodies = 9'(n);
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      wait_frame(tag);
   endtask

   task automatic after_frame(input string tag, input int offs);
      check({tag, "_wr_count"}, wr_log.size(), 2);
      check({tag, "_wr_set"}, wr_log[0], {16'h0200, 64'd1});
      check({tag, "_wr_clr"}, wr_log[1], {16'h0200, 64'd0});
      check({tag, "_off_count"}, off_count, offs);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
      @(negedge clk);
      check({tag, "_fd_pulse"}, frame_done, 0);
      check({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      int mg, k;
      logic [28:0] snap;
      int s0;
      bit chg;
      repeat (3) @(negedge clk);
      check("reset_bus", {nb_chipselect, nb_read, nb_write, nb_addr}, 0);
      check("reset_wdata", nb_writedata, 0);
      check("reset_pt", {pt_valid, pt_x, pt_y, pt_idx, pt_last, frame_done, busy, off_count}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // DONE polled three times low before it rises; one body at (100,-50).
      done_q = '{1'b0, 1'b0, 1'b0};
      body(0, 64'h4059000000000000, 64'hC049000000000000);
      exp_q.push_back(pt(420, 290, 0, 1'b1));
      clear_logs();
      run_frame(1, "t1");
      check("t1_polls", poll_cyc.size(), 4);
      mg = 1000;
      for (int j = 1; j < poll_cyc.size(); j++)
         if (poll_cyc[j] - poll_cyc[j-1] < mg) mg = poll_cyc[j] - poll_cyc[j-1];
      check("t1_poll_gap", mg >= 16, 1);
      check("t1_rd_count", rd_log.size(), 6);
      check("t1_rd_poll4", rd_log[3], 16'h8000);
      check("t1_rd_x0", rd_log[4], 16'h8200);
      check("t1_rd_y0", rd_log[5], 16'h8400);
      after_frame("t1", 0);

      // Conversion patterns, including an off-screen final body.
      body(0, 64'h3FE8000000000000, 64'hBFE8000000000000);
      body(1, 64'h7FF0000000000000, 64'h0000000000000000);
      body(2, 64'h408F400000000000, 64'h0000000000000000);
      body(3, 64'hC004000000000000, 64'h400F333333333333);
      body(4, 64'h0000000000000000, 64'hC08F400000000000);
`ifdef NBODY_READBACK_CLAMP_EN
      exp_q.push_back(pt(320, 240, 0, 1'b0));
      exp_q.push_back(pt(639, 240, 1, 1'b0));
      exp_q.push_back(pt(639, 240, 2, 1'b0));
      exp_q.push_back(pt(318, 237, 3, 1'b0));
      exp_q.push_back(pt(320, 479, 4, 1'b1));
`else
      exp_q.push_back(pt(320, 240, 0, 1'b0));
      exp_q.push_back(pt(318, 237, 3, 1'b0));
`endif
      clear_logs();
      run_frame(5, "t2");
      check("t2_rd_count", rd_log.size(), 11);
      after_frame("t2", 3);

      // Zero bodies: one poll, release only.
      clear_logs();
      run_frame(0, "t4");
      check("t4_rd_count", rd_log.size(), 1);
      after_frame("t4", 0);

      // Back-pressure on body 1 must freeze the point and the bus.
      body(0, 64'h3FE8000000000000, 64'hBFE8000000000000);
      body(1, 64'h4059000000000000, 64'hC049000000000000);
      body(2, 64'hC004000000000000, 64'h400F333333333333);
      exp_q.push_back(pt(320, 240, 0, 1'b0));
      exp_q.push_back(pt(420, 290, 1, 1'b0));
      exp_q.push_back(pt(318, 237, 2, 1'b1));
      clear_logs();
      @(posedge clk); #1 pt_ready = 1'b0;
      num_bodies = 9'd3;
      start = 1'b1;
      wait_valid("t3_b0");
      start = 1'b0;
      @(posedge clk); #1 pt_ready = 1'b1;
      @(posedge clk); #1 pt_ready = 1'b0;
      @(negedge clk);
      wait_valid("t3_b1");
      check("t3_stall_idx", pt_idx, 1);
      snap = {pt_x, pt_y, pt_idx};
      s0 = strobes;
      chg = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if ({pt_x, pt_y, pt_idx} !== snap || pt_valid !== 1'b1) chg = 1'b1;
      end
      check("t3_stall_stable", chg, 0);
      check("t3_stall_strobes", strobes - s0, 0);
      @(posedge clk); #1 pt_ready = 1'b1;
      wait_frame("t3");
      after_frame("t3", 0);

      // Reset in WAIT_Y clears everything asynchronously.
      body(0, 64'h4059000000000000, 64'hC049000000000000);
      num_bodies = 9'd1;
      start = 1'b1;
      k = 0;
      while (!(nb_addr === 16'h8400 && nb_read === 1'b0) && k < 500) begin @(negedge clk); k++; end
      check("t5_reach_wait_y", nb_addr, 16'h8400);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("t5_rst_bus", {nb_chipselect, nb_read, nb_write, nb_addr}, 0);
      check("t5_rst_pt", {pt_valid, pt_x, pt_y, pt_idx, pt_last, frame_done, busy, off_count}, 0);
      @(posedge clk); #1;
      check("t5_rst_hold", {busy, pt_valid, nb_chipselect}, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(pt(420, 290, 0, 1'b1));
      clear_logs();
      run_frame(1, "t6");
      after_frame("t6", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
